tea_arbiter: RTL and testbench



---
 rtl/tea_pkg.sv | 22 ++
 rtl/tea_rr_arbiter.sv | 18 +
 rtl/tea_arbiter.sv | 126 ++++++++++++
 tb/tb_tea_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA core arbiter.
package tea_pkg;

  localparam int TEA_ROUNDS  = 32;
  localparam int TEA_BLOCK_W = 64;
  localparam int TEA_KEY_W   = 128;
  localparam int TEA_NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_CORE,
    RETURN
  } arb_state_e;

  // One-hot requester mask from a requester index.
  function automatic logic [TEA_NUM_REQ-1:0] req_bit(input logic idx);
    req_bit      = '0;
    req_bit[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/tea_rr_arbiter.sv
// Combinational 2-way round-robin grant: pointer breaks ties, a lone requester always wins.
module tea_rr_arbiter
  import tea_pkg::*;
(
  input  logic [TEA_NUM_REQ-1:0] req,
  input  logic                   ptr,
  output logic                   gnt_vld,
  output logic                   gnt_idx
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = ptr;
    if (req[0] && !req[1])      gnt_idx = 1'b0;
    else if (req[1] && !req[0]) gnt_idx = 1'b1;
  end

endmodule

// File: rtl/tea_arbiter.sv
// Two-requester arbiter sharing one TEA core over AXI-Stream-style handshakes.
// Optional abort of a stalled core transaction when TEA_ARB_TIMEOUT_EN is defined.
module tea_arbiter
  import tea_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic [TEA_NUM_REQ-1:0][TEA_KEY_W-1:0]   i_key,
  input  logic [TEA_NUM_REQ-1:0]                  i_axis_valid_s,
  output logic [TEA_NUM_REQ-1:0]                  o_axis_ready_s,
  input  logic [TEA_NUM_REQ-1:0][TEA_BLOCK_W-1:0] i_axis_data_s,
  output logic [TEA_NUM_REQ-1:0]                  o_axis_valid_m,
  input  logic [TEA_NUM_REQ-1:0]                  i_axis_ready_m,
  output logic [TEA_NUM_REQ-1:0][TEA_BLOCK_W-1:0] o_axis_data_m,
  output logic [TEA_KEY_W-1:0]                    o_core_key,
  output logic                                    o_core_valid,
  input  logic                                    i_core_ready,
  output logic [TEA_BLOCK_W-1:0]                  o_core_data,
  input  logic                                    i_core_valid,
  output logic                                    o_core_ready,
  input  logic [TEA_BLOCK_W-1:0]                  i_core_data,
  output logic                                    o_busy,
  output logic                                    o_owner,
  output logic                                    o_timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e state, state_nxt;

  logic                   ptr;
  logic                   owner;
  logic [TEA_BLOCK_W-1:0] blk;
  logic [TEA_KEY_W-1:0]   key;
  logic [TEA_BLOCK_W-1:0] res;
  logic                   gnt_vld;
  logic                   gnt_idx;
  logic [TEA_NUM_REQ-1:0] ready_s;
  logic                   timeout_hit;

  tea_rr_arbiter u_rr (
    .req     (i_axis_valid_s),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

`ifdef TEA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_flag;

  // Counts consecutive cycles spent waiting on the core; fires on the last allowed one.
  assign timeout_hit = ((state == ISSUE) || (state == WAIT_CORE)) &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (((state == ISSUE) || (state == WAIT_CORE)) && !timeout_hit) to_cnt <= to_cnt + 1'b1;
      else                                                           to_cnt <= '0;
      if (timeout_hit) to_flag <= 1'b1;
    end
  end

  assign o_timeout = to_flag;
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    o_busy         = (state != IDLE);
    o_core_valid   = (state == ISSUE);
    o_core_ready   = (state == WAIT_CORE);
    o_axis_valid_m = (state == RETURN) ? req_bit(owner) : '0;
    ready_s        = ((state == IDLE) && gnt_vld) ? req_bit(gnt_idx) : '0;
    case (state)
      IDLE:      if (gnt_vld)               state_nxt = ISSUE;
      ISSUE:     if (i_core_ready)          state_nxt = WAIT_CORE;
      WAIT_CORE: if (i_core_valid)          state_nxt = RETURN;
      RETURN:    if (i_axis_ready_m[owner]) state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = IDLE;
  end

  // Ready is combinational from the request inputs, so hold it low while reset is asserted.
  assign o_axis_ready_s = ready_s & {TEA_NUM_REQ{i_rst_n}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr   <= 1'b0;
      owner <= 1'b0;
      blk   <= '0;
      key   <= '0;
      res   <= '0;
    end else begin
      if ((state == IDLE) && gnt_vld) begin
        blk   <= i_axis_data_s[gnt_idx];
        key   <= i_key[gnt_idx];
        owner <= gnt_idx;
      end
      if ((state == WAIT_CORE) && i_core_valid && !timeout_hit) res <= i_core_data;
      if (((state == RETURN) && i_axis_ready_m[owner]) || timeout_hit) ptr <= ~owner;
    end
  end

  assign o_core_key    = key;
  assign o_core_data   = blk;
  assign o_owner       = owner;
  assign o_axis_data_m = {TEA_NUM_REQ{res}};

endmodule

// File: tb/tb_tea_arbiter.sv
// Directed bench for tea_arbiter with a 32-cycle TEA core model; timeout case under TEA_ARB_TIMEOUT_EN.
module tb_tea_arbiter;

  localparam int CORE_LAT = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0][127:0] key;
  logic [1:0]        s_valid;
  logic [1:0]        s_ready;
  logic [1:0][63:0]  s_data;
  logic [1:0]        m_valid;
  logic [1:0]        m_ready;
  logic [1:0][63:0]  m_data;
  logic [127:0]      core_key;
  logic              core_valid;
  logic              core_in_ready;
  logic [63:0]       core_data;
  logic              core_out_valid;
  logic              core_ready;
  logic [63:0]       core_out_data;
  logic              busy;
  logic              owner;
  logic              timeout;

  logic              core_stuck;
  logic              cm_busy;
  int                cm_cnt;
  logic [63:0]       cm_res;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tea_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_key          (key),
    .i_axis_valid_s (s_valid),
    .o_axis_ready_s (s_ready),
    .i_axis_data_s  (s_data),
    .o_axis_valid_m (m_valid),
    .i_axis_ready_m (m_ready),
    .o_axis_data_m  (m_data),
    .o_core_key     (core_key),
    .o_core_valid   (core_valid),
    .i_core_ready   (core_in_ready),
    .o_core_data    (core_data),
    .i_core_valid   (core_out_valid),
    .o_core_ready   (core_ready),
    .i_core_data    (core_out_data),
    .o_busy         (busy),
    .o_owner        (owner),
    .o_timeout      (timeout)
  );

  function automatic logic [63:0] tea_enc(input logic [63:0] d, input logic [127:0] k);
    logic [31:0] v0, v1, s;
    v0 = d[63:32];
    v1 = d[31:0];
    s  = 32'h0;
    for (int r = 0; r < 32; r++) begin
      s  = s + 32'h9E3779B9;
      v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
      v1 = v1 + (((v0 << 4) + k[63:32])  ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v0, v1};
  endfunction

  // Core model: accept one block, present the result CORE_LAT cycles later; stuck mode drops it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_busy        <= 1'b0;
      cm_cnt         <= 0;
      cm_res         <= '0;
      core_out_valid <= 1'b0;
      core_out_data  <= '0;
    end else if (!cm_busy) begin
      if (core_valid) begin
        cm_busy <= !core_stuck;
        cm_cnt  <= 0;
        cm_res  <= tea_enc(core_data, core_key);
      end
    end else if (!core_out_valid) begin
      if (cm_cnt == CORE_LAT - 1) begin
        core_out_valid <= 1'b1;
        core_out_data  <= cm_res;
      end else begin
        cm_cnt <= cm_cnt + 1;
      end
    end else if (core_ready) begin
      core_out_valid <= 1'b0;
      cm_busy        <= 1'b0;
    end
  end
  assign core_in_ready = !cm_busy;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int r);
    return (r == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = '0;
    m_ready = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Waits for the grant to requester r, then checks the block presented to the core.
  task automatic expect_grant(input int r, input logic [63:0] d, input logic [127:0] k);
    int n = 0;
    #1;
    while (s_ready == 2'b00 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("grant", s_ready, oh(r));
    @(negedge clk);
    s_valid[r] = 1'b0;
    #1;
    chk("issue_valid", core_valid, 1'b1);
    chk("issue_data", core_data, d);
    chk("issue_key", core_key, k);
    chk("issue_owner", owner, r[0]);
    chk("issue_ready_s", s_ready, 2'b00);
  endtask

  // Waits for the result, optionally stalls the owner's ready for hold cycles, then completes it.
  task automatic finish_block(input int r, input logic [63:0] d, input logic [127:0] k, input int hold);
    int   n          = 0;
    logic other_seen = 1'b0;
    logic [63:0] exp_res;
    exp_res = tea_enc(d, k);
    while (m_valid == 2'b00 && n < 200) begin
      @(negedge clk); #1;
      n++;
      if (m_valid[(r == 0) ? 1 : 0]) other_seen = 1'b1;
    end
    chk("ret_latency", n, CORE_LAT + 2);
    chk("ret_valid", m_valid, oh(r));
    chk("ret_other_never", other_seen, 1'b0);
    chk("ret_data", m_data[r], exp_res);
    chk("ret_owner", owner, r[0]);
    for (int i = 0; i < hold; i++) begin
      m_ready = oh((r == 0) ? 1 : 0);
      @(negedge clk); #1;
      chk("hold_valid", m_valid, oh(r));
      chk("hold_data", m_data[r], exp_res);
      chk("hold_busy", busy, 1'b1);
      chk("hold_ready_s", s_ready, 2'b00);
    end
    m_ready = oh(r);
    @(negedge clk);
    m_ready = 2'b00;
    #1;
    chk("ret_done_valid", m_valid, 2'b00);
    chk("ret_done_busy", busy, 1'b0);
  endtask

  initial begin
    core_stuck = 1'b0;
    key        = '0;
    s_data     = '0;
    rst_n      = 1'b0;
    s_valid    = '0;
    m_ready    = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready_s", s_ready, 2'b00);
    chk("rst_valid_m", m_valid, 2'b00);
    chk("rst_core_valid", core_valid, 1'b0);
    chk("rst_core_ready", core_ready, 1'b0);
    chk("rst_core_key", core_key, 128'h0);
    chk("rst_data_m", m_data, 128'h0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    do_reset();

    // Requester 0 alone, key 1, data 1.
    @(negedge clk);
    key[0] = 128'h1; s_data[0] = 64'h1; s_valid[0] = 1'b1;
    expect_grant(0, 64'h1, 128'h1);
    finish_block(0, 64'h1, 128'h1, 0);

    // Both valid straight after reset: req0 then req1, and again req0 first.
    do_reset();
    @(negedge clk);
    key[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; s_data[0] = 64'hDEAD_BEEF_0000_0001;
    key[1] = 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0; s_data[1] = 64'h0000_0002_CAFE_F00D;
    s_valid = 2'b11;
    for (int rep = 0; rep < 2; rep++) begin
      expect_grant(0, s_data[0], key[0]);
      finish_block(0, s_data[0], key[0], 0);
      expect_grant(1, s_data[1], key[1]);
      finish_block(1, s_data[1], key[1], 0);
      s_valid = 2'b11;
    end
    s_valid = 2'b00;

    // Requester 1 alone, two blocks back to back.
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      s_data[1] = 64'h1111_2222_3333_4444 + 64'(b);
      s_valid[1] = 1'b1;
      expect_grant(1, s_data[1], key[1]);
      finish_block(1, s_data[1], key[1], 0);
    end

    // Result held 10 cycles with requester 1 pending and non-owner ready ignored.
    @(negedge clk);
    s_data[0] = 64'h5555_AAAA_5555_AAAA;
    s_valid   = 2'b11;
    expect_grant(0, s_data[0], key[0]);
    finish_block(0, s_data[0], key[0], 10);
    expect_grant(1, s_data[1], key[1]);
    finish_block(1, s_data[1], key[1], 0);

    // Reset asserted while waiting on the core.
    @(negedge clk);
    s_data[0] = 64'h7777_8888_9999_0000;
    s_valid[0] = 1'b1;
    expect_grant(0, s_data[0], key[0]);
    repeat (5) @(negedge clk);
    #1;
    chk("wait_core_ready", core_ready, 1'b1);
    s_valid[1] = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_core_ready", core_ready, 1'b0);
    chk("mid_rst_core_valid", core_valid, 1'b0);
    chk("mid_rst_ready_s", s_ready, 2'b00);
    chk("mid_rst_valid_m", m_valid, 2'b00);
    chk("mid_rst_core_key", core_key, 128'h0);
    chk("mid_rst_core_data", core_data, 64'h0);
    chk("mid_rst_data_m", m_data, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_grant(1, s_data[1], key[1]);
    finish_block(1, s_data[1], key[1], 0);

`ifdef TEA_ARB_TIMEOUT_EN
    begin
      int n = 0;
      @(negedge clk);
      core_stuck = 1'b1;
      s_data[0]  = 64'h0BAD_0BAD_0BAD_0BAD;
      s_valid[0] = 1'b1;
      expect_grant(0, s_data[0], key[0]);
      while (!timeout && n < 200) begin
        @(negedge clk); #1;
        n++;
      end
      chk("timeout_cycle", n, 64);
      chk("timeout_flag", timeout, 1'b1);
      chk("timeout_idle", busy, 1'b0);
      core_stuck = 1'b0;
      s_valid[0] = 1'b1;
      expect_grant(0, s_data[0], key[0]);
      finish_block(0, s_data[0], key[0], 0);
      chk("timeout_sticky", timeout, 1'b1);
    end
`else
    chk("timeout_tied", timeout, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
